axis_ad5791: RTL and testbench

AXIS_AD5791 -- requirements
Module: axis_ad5791

---
 rtl/ad5791_pkg.sv | 25 ++
 rtl/ad5791_shift.sv | 65 ++++++
 rtl/axis_ad5791.sv | 161 ++++++++++++++++
 tb/tb_axis_ad5791.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad5791_pkg.sv
// Shared definitions for the four-lane AD5791 DAC driver: frame geometry,
// the DAC register addresses and the control FSM states.
package ad5791_pkg;

  localparam int FRAME_W = 24;
  localparam int LANES   = 4;
  localparam int DAC_W   = 20;

  typedef enum logic [2:0] {
    REG_DAC    = 3'b001,
    REG_CTRL   = 3'b010,
    REG_CLR    = 3'b011,
    REG_SWCTRL = 3'b100
  } reg_addr_t;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  typedef logic [FRAME_W-1:0] frame_t;

  // Write frame for the DAC register: R/W bit low, address, 20-bit code.
  function automatic frame_t dac_write(input logic [DAC_W-1:0] value);
    return {1'b0, REG_DAC, value};
  endfunction

endpackage

// File: rtl/ad5791_shift.sv
// Four-lane MSB-first serializer sharing one SCLK. Data changes on the
// falling SCLK edge; `last` flags the cycle that ends the final falling edge.
module ad5791_shift
  import ad5791_pkg::*;
#(
  parameter int SCLK_HALF = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  frame_t [LANES-1:0]     data,
  output logic                   sclk,
  output logic [LANES-1:0]       sdin,
  output logic                   last
);

  localparam int                 CNT_W     = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CNT_W-1:0]   PHASE_END = CNT_W'(SCLK_HALF - 1);
  localparam logic [4:0]         LAST_BIT  = 5'(FRAME_W - 1);

  logic [CNT_W-1:0]   cnt;
  logic [4:0]         bit_cnt;
  logic               active;
  frame_t [LANES-1:0] sr;
  logic               phase_end;

  assign phase_end = (cnt == PHASE_END);
  assign last      = active && sclk && phase_end && (bit_cnt == LAST_BIT);

  always_comb begin
    sdin = '0;
    for (int k = 0; k < LANES; k++) sdin[k] = sr[k][FRAME_W-1];
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= 1'b0;
      sclk    <= 1'b0;
      cnt     <= '0;
      bit_cnt <= '0;
      sr      <= '0;
    end else if (load) begin
      active  <= 1'b1;
      sclk    <= 1'b0;
      cnt     <= '0;
      bit_cnt <= '0;
      sr      <= data;
    end else if (active) begin
      if (phase_end) begin
        cnt  <= '0;
        sclk <= ~sclk;
        // Zeros shift in, so sdin idles low once the last bit has gone.
        if (sclk) begin
          for (int k = 0; k < LANES; k++) sr[k] <= {sr[k][FRAME_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) active <= 1'b0;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_ad5791.sv
// AXI-Stream front end driving four AD5791 DACs over one shared SPI bus.
// Define AD5791_LDAC_EN to add an ldac_n strobe after run-mode frames.
module axis_ad5791
  import ad5791_pkg::*;
#(
  parameter int SCLK_HALF = 2,
  parameter int SYNC_GAP  = 4
) (
  input  logic        a_clk,
  input  logic        reset,
  input  logic [31:0] S_AXIS1_tdata,
  input  logic        S_AXIS1_tvalid,
  input  logic [31:0] S_AXIS2_tdata,
  input  logic        S_AXIS2_tvalid,
  input  logic [31:0] S_AXIS3_tdata,
  input  logic        S_AXIS3_tvalid,
  input  logic [31:0] S_AXIS4_tdata,
  input  logic        S_AXIS4_tvalid,
  input  logic [31:0] S_AXISCFG_tdata,
  input  logic        S_AXISCFG_tvalid,
  input  logic        configuration_mode,
  input  logic [2:0]  configuration_axis,
  input  logic        configuration_send,
  output logic        dac_sclk,
  output logic        dac_sync_n,
  output logic [3:0]  dac_sdin,
  output logic        busy
`ifdef AD5791_LDAC_EN
  ,
  output logic        ldac_n
`endif
);

  localparam int               GAP_W   = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_END = GAP_W'(SYNC_GAP - 1);

  state_t                       state, next_state;
  logic [LANES-1:0][DAC_W-1:0]  axis_value, pending, last_sent, run_value;
  logic [LANES-1:0]             axis_valid, dirty;
  frame_t [LANES-1:0]           cfg_word, frame_data;
  logic [GAP_W-1:0]             gap_cnt;
  logic                         frame_cfg, send_q, send_pend, send_edge;
  logic                         start, load, shift_last;
  logic                         unused_bits;

  assign axis_value = {S_AXIS4_tdata[31:12], S_AXIS3_tdata[31:12],
                       S_AXIS2_tdata[31:12], S_AXIS1_tdata[31:12]};
  assign axis_valid = {S_AXIS4_tvalid, S_AXIS3_tvalid, S_AXIS2_tvalid, S_AXIS1_tvalid};
  assign unused_bits = ^{S_AXIS4_tdata[11:0], S_AXIS3_tdata[11:0], S_AXIS2_tdata[11:0],
                         S_AXIS1_tdata[11:0], S_AXISCFG_tdata[31:FRAME_W]};

  assign send_edge = configuration_send && !send_q;
  assign busy      = (state != IDLE);

  // NOTE: defaults first so no path leaves a signal unassigned (no latch).
  always_comb begin
    next_state = state;
    start      = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (configuration_mode ? send_pend : |dirty) begin
          next_state = LOAD;
          start      = 1'b1;
        end
      end
      LOAD: begin
        load       = 1'b1;
        next_state = SHIFT;
      end
      SHIFT: if (shift_last) next_state = GAP;
      GAP:   if (gap_cnt == GAP_END) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Lanes without fresh data repeat the code they last put on the DAC.
  always_comb begin
    run_value  = '0;
    frame_data = '0;
    for (int k = 0; k < LANES; k++) begin
      run_value[k]  = dirty[k] ? pending[k] : last_sent[k];
      frame_data[k] = frame_cfg ? cfg_word[k] : dac_write(run_value[k]);
    end
  end

  always_ff @(posedge a_clk) begin
    if (reset) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      frame_cfg  <= 1'b0;
      dac_sync_n <= 1'b1;
      send_q     <= 1'b0;
      send_pend  <= 1'b0;
    end else begin
      state      <= next_state;
      gap_cnt    <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      dac_sync_n <= !(next_state == LOAD || next_state == SHIFT);
      send_q     <= configuration_send;
      if (start) frame_cfg <= configuration_mode;
      // A new edge wins over consumption so a request during busy is kept.
      if (send_edge && configuration_mode)  send_pend <= 1'b1;
      else if (start && configuration_mode) send_pend <= 1'b0;
    end
  end

  always_ff @(posedge a_clk) begin
    if (reset) begin
      dirty     <= '0;
      last_sent <= '0;
      cfg_word  <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (axis_valid[k])            dirty[k] <= 1'b1;
        else if (load && !frame_cfg)  dirty[k] <= 1'b0;
      end
      if (load && !frame_cfg) last_sent <= run_value;
      if (S_AXISCFG_tvalid && !configuration_axis[2])
        cfg_word[configuration_axis[1:0]] <= S_AXISCFG_tdata[FRAME_W-1:0];
    end
  end

  // NOTE: no reset on pending: dirty qualifies it, so its contents never matter until written.
  always_ff @(posedge a_clk) begin
    for (int k = 0; k < LANES; k++)
      if (axis_valid[k]) pending[k] <= axis_value[k];
  end

  ad5791_shift #(.SCLK_HALF(SCLK_HALF)) u_shift (
    .clk   (a_clk),
    .reset (reset),
    .load  (load),
    .data  (frame_data),
    .sclk  (dac_sclk),
    .sdin  (dac_sdin),
    .last  (shift_last)
  );

`ifdef AD5791_LDAC_EN
  localparam int                LDAC_LEN = 2 * SCLK_HALF;
  localparam int                LDAC_W   = $clog2(LDAC_LEN);
  localparam logic [LDAC_W-1:0] LDAC_END = LDAC_W'(LDAC_LEN - 1);

  logic [LDAC_W-1:0] ldac_cnt;

  // Counts independently of GAP so a short SYNC gap cannot truncate the pulse.
  always_ff @(posedge a_clk) begin
    if (reset) begin
      ldac_n   <= 1'b1;
      ldac_cnt <= '0;
    end else if (state == SHIFT && shift_last && !frame_cfg) begin
      ldac_n   <= 1'b0;
      ldac_cnt <= '0;
    end else if (!ldac_n) begin
      if (ldac_cnt == LDAC_END) ldac_n <= 1'b1;
      ldac_cnt <= ldac_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_ad5791.sv
// Scoreboard bench for axis_ad5791: directed stimulus queues expected frames,
// a negedge monitor deserializes the four lanes and compares them.
module tb_axis_ad5791;

  localparam int SH = 2;
  localparam int SG = 4;

  logic        a_clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s1_tdata = '0, s2_tdata = '0, s3_tdata = '0, s4_tdata = '0;
  logic        s1_tvalid = 1'b0, s2_tvalid = 1'b0, s3_tvalid = 1'b0, s4_tvalid = 1'b0;
  logic [31:0] cfg_tdata = '0;
  logic        cfg_tvalid = 1'b0;
  logic        configuration_mode = 1'b0;
  logic [2:0]  configuration_axis = '0;
  logic        configuration_send = 1'b0;
  logic        dac_sclk, dac_sync_n, busy;
  logic [3:0]  dac_sdin;
`ifdef AD5791_LDAC_EN
  logic        ldac_n;
`endif

  axis_ad5791 #(.SCLK_HALF(SH), .SYNC_GAP(SG)) dut (
    .a_clk              (a_clk),
    .reset              (reset),
    .S_AXIS1_tdata      (s1_tdata),
    .S_AXIS1_tvalid     (s1_tvalid),
    .S_AXIS2_tdata      (s2_tdata),
    .S_AXIS2_tvalid     (s2_tvalid),
    .S_AXIS3_tdata      (s3_tdata),
    .S_AXIS3_tvalid     (s3_tvalid),
    .S_AXIS4_tdata      (s4_tdata),
    .S_AXIS4_tvalid     (s4_tvalid),
    .S_AXISCFG_tdata    (cfg_tdata),
    .S_AXISCFG_tvalid   (cfg_tvalid),
    .configuration_mode (configuration_mode),
    .configuration_axis (configuration_axis),
    .configuration_send (configuration_send),
    .dac_sclk           (dac_sclk),
    .dac_sync_n         (dac_sync_n),
    .dac_sdin           (dac_sdin),
    .busy               (busy)
`ifdef AD5791_LDAC_EN
    ,
    .ldac_n             (ldac_n)
`endif
  );

  always #5 a_clk = ~a_clk;

  int checks   = 0;
  int failures = 0;
  logic [3:0][23:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [23:0] l3, input logic [23:0] l2,
                              input logic [23:0] l1, input logic [23:0] l0);
    exp_q.push_back({l3, l2, l1, l0});
  endtask

  // Monitor: capture each lane on SCLK rising (data is stable through the high phase).
  int               nbits = 0;
  int               frame_idx = 0;
  int               unstable = 0;
  logic [3:0][23:0] cap = '0;
  logic [3:0][23:0] exp_frame;
  logic             sclk_prev = 1'b0;
  logic [3:0]       sdin_prev = '0;

  always @(negedge a_clk) begin
    if (reset || dac_sync_n) begin
      nbits    = 0;
      unstable = 0;
    end else begin
      if (dac_sclk && sclk_prev && dac_sdin !== sdin_prev) unstable++;
      if (dac_sclk && !sclk_prev) begin
        for (int k = 0; k < 4; k++) cap[k] = {cap[k][22:0], dac_sdin[k]};
        nbits++;
        if (nbits == 24) begin
          check($sformatf("frame%0d_expected", frame_idx), 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            exp_frame = exp_q.pop_front();
            for (int k = 0; k < 4; k++)
              check($sformatf("frame%0d_lane%0d", frame_idx, k), 32'(cap[k]), 32'(exp_frame[k]));
          end
          check($sformatf("frame%0d_sdin_stable_sclk_high", frame_idx), 32'(unstable), 32'd0);
          frame_idx++;
          nbits = 0;
        end
      end
    end
    sclk_prev = dac_sclk;
    sdin_prev = dac_sdin;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge a_clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [2:0] axis, input logic [31:0] data);
    cfg_tdata = data; configuration_axis = axis; cfg_tvalid = 1'b1;
    cycles(1);
    cfg_tvalid = 1'b0;
  endtask

  task automatic axis_write(input int n, input logic [31:0] data);
    case (n)
      1: begin s1_tdata = data; s1_tvalid = 1'b1; end
      2: begin s2_tdata = data; s2_tvalid = 1'b1; end
      3: begin s3_tdata = data; s3_tvalid = 1'b1; end
      default: begin s4_tdata = data; s4_tvalid = 1'b1; end
    endcase
    cycles(1);
    {s1_tvalid, s2_tvalid, s3_tvalid, s4_tvalid} = '0;
  endtask

  task automatic send_pulse();
    configuration_send = 1'b1;
    cycles(1);
    configuration_send = 1'b0;
    cycles(1);
  endtask

  task automatic wait_sync_low(input string name);
    int t = 0;
    while (dac_sync_n && t < 200) begin cycles(1); t++; end
    check(name, 32'(dac_sync_n), 32'd0);
  endtask

  // Wait until the block has been idle for 3 consecutive cycles.
  task automatic drain(input string name);
    int quiet = 0;
    int t = 0;
    while (quiet < 3 && t < 3000) begin
      cycles(1);
      t++;
      quiet = busy ? 0 : quiet + 1;
    end
    check(name, 32'(quiet), 32'd3);
  endtask

  task automatic expect_quiet(input string name, input int n);
    int act = 0;
    repeat (n) begin
      cycles(1);
      if (busy || !dac_sync_n) act++;
    end
    check(name, 32'(act), 32'd0);
  endtask

  initial begin
    int lo, gap, rises, edges, t;
    logic prev;

    cycles(3);
    check("reset_sclk", 32'(dac_sclk), 32'd0);
    check("reset_sync_n", 32'(dac_sync_n), 32'd1);
    check("reset_sdin", 32'(dac_sdin), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    cycles(2);

    // Config frame and frame timing.
    configuration_mode = 1'b1;
    cfg_write(3'd0, 32'd16);
    cfg_write(3'd1, 32'd32);
    cfg_write(3'd2, 32'd64);
    cfg_write(3'd3, 32'd128);
    expect_frame(24'h000080, 24'h000040, 24'h000020, 24'h000010);
    configuration_send = 1'b1;
    t = 0;
    while (dac_sync_n && t < 50) begin cycles(1); t++; end
    configuration_send = 1'b0;
    check("cfg_sync_fall", 32'(dac_sync_n), 32'd0);
    lo = 0;
    while (!dac_sync_n && lo < 500) begin lo++; cycles(1); end
    check("sync_low_cycles", 32'(lo), 32'd97);
    gap = 0;
    while (dac_sync_n && busy && gap < 50) begin gap++; cycles(1); end
    check("sync_gap_cycles", 32'(gap), 32'(SG));
    check("idle_after_gap", 32'(busy), 32'd0);
    drain("drain_cfg");

    // Run mode: single new lane, others resend cleared last values.
    configuration_mode = 1'b0;
    expect_frame(24'h100000, 24'h100000, 24'h100000, 24'h100100);
    axis_write(1, 32'h0010_0000);
    drain("drain_run1");

    expect_frame(24'h100000, 24'h100000, 24'h1FFFFF, 24'h100100);
    axis_write(2, 32'hFFFF_F000);
    drain("drain_run2");

    // Update during SHIFT only affects the following frame.
    expect_frame(24'h100400, 24'h100000, 24'h1FFFFF, 24'h100100);
    expect_frame(24'h100400, 24'h100000, 24'h1FFFFF, 24'h100200);
    axis_write(4, 32'h0040_0000);
    wait_sync_low("midframe_sync_fall");
    cycles(20);
    axis_write(1, 32'h0020_0000);
    drain("drain_midframe");

    // Run data in config mode is held back until run mode resumes.
    configuration_mode = 1'b1;
    axis_write(3, 32'h0000_1000);
    expect_quiet("cfg_mode_holds_run_data", 300);
    expect_frame(24'h100400, 24'h100001, 24'h1FFFFF, 24'h100200);
    configuration_mode = 1'b0;
    drain("drain_resume");

    // A send edge in run mode is not remembered.
    send_pulse();
    expect_quiet("run_mode_send_ignored", 200);
    configuration_mode = 1'b1;
    expect_quiet("no_stale_send", 200);

    // Ignored axis values, and a send edge remembered while busy.
    cfg_write(3'd5, 32'h0012_3456);
    cfg_write(3'd4, 32'h0065_4321);
    expect_frame(24'h000080, 24'h000040, 24'h000020, 24'h000010);
    expect_frame(24'h000080, 24'h000040, 24'h000020, 24'h0ABCDE);
    send_pulse();
    cycles(30);
    check("busy_during_frame", 32'(busy), 32'd1);
    cfg_write(3'd0, 32'hFF0A_BCDE);
    send_pulse();
    drain("drain_pending_send");

    // Reset at bit 10 aborts the frame.
    configuration_mode = 1'b0;
    axis_write(1, 32'h0050_0000);
    wait_sync_low("abort_sync_fall");
    rises = 0;
    prev  = dac_sclk;
    t     = 0;
    while (rises < 10 && t < 1000) begin
      cycles(1);
      t++;
      if (dac_sclk && !prev) rises++;
      prev = dac_sclk;
    end
    check("abort_reached_bit10", 32'(rises), 32'd10);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check("abort_sync_n_high", 32'(dac_sync_n), 32'd1);
    check("abort_sclk_low", 32'(dac_sclk), 32'd0);
    check("abort_busy_low", 32'(busy), 32'd0);
    edges = 0;
    prev  = dac_sclk;
    repeat (300) begin
      cycles(1);
      if (dac_sclk !== prev) edges++;
      prev = dac_sclk;
    end
    check("abort_no_sclk_edges", 32'(edges), 32'd0);

    // Reset cleared config words and last-sent values.
    configuration_mode = 1'b1;
    expect_frame(24'h000000, 24'h000000, 24'h000000, 24'h000000);
    send_pulse();
    drain("drain_cfg_cleared");
    configuration_mode = 1'b0;
    expect_frame(24'h17FFFF, 24'h100000, 24'h100000, 24'h100000);
    axis_write(4, 32'h7FFF_F000);
    drain("drain_last_cleared");

    cycles(5);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
